b1_vec_pipe: RTL and testbench
==============================

Name: b1_vec_pipe

Overview:
Parametrised, pipelined successor of the three-input b1 logic cell.
- Processes WIDTH-bit vectors a, b, c bit-parallel.
- Produces the four b1-style outputs (d, e, f, g) with a run-time selectable f-function.
- Registers results through a STAGES-deep elastic valid/ready pipeline.
- Keeps a saturating count of delivered results whose f-vector is non-zero.
- Sits between a stimulus source and a checker/sink in the benchmark harness.

Parameters:
WIDTH, 8, bit width of each operand and result vector (>=1)
STAGES, 2, number of pipeline register stages (1..4)
CNT_W, 16, width of hit counter (>=2)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  pipeline can accept input this cycle
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
in_c  in  WIDTH  operand c
in_mode  in  2  f-function select, travels with the transaction
out_valid  out  1  output transaction valid
out_ready  in  1  sink accepts output this cycle
out_d  out  WIDTH  registered c
out_e  out  WIDTH  registered a^b
out_f  out  WIDTH  registered selected function
out_g  out  WIDTH  registered ~c
hit_cnt  out  CNT_W  count of output handshakes with out_f != 0
cnt_clr  in  1  synchronous clear of hit_cnt
busy  out  1  OR of all stage valid bits

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Combinational compute, per bit i, evaluated before stage 0:
  - d = c; e = a^b; g = ~c.
  - f by in_mode:
    - 00: (~a&~b&c) | (a&b&~c), the b1 function
    - 01: a^b^c
    - 10: majority (a&b) | (a&c) | (b&c)
    - 11: ~(a^b^c)
- Pipeline: stages 0..STAGES-1, each holding valid bit v[k] plus d/e/f/g vectors.
  - Stage k advances when v[k]=0 or stage k+1 advances; the last stage advances when out_ready=1 or v[last]=0.
  - in_ready = stage 0 advances (combinational ready chain). Input is accepted when in_valid & in_ready.
  - Stage k loads from stage k-1, or from compute logic for k=0, when it advances. Its valid becomes the upstream valid/accept.
  - out_valid = v[last]; out_d/e/f/g = last-stage registers.
  - Latency: accepted input appears at the outputs exactly STAGES cycles later when there is no backpressure.
  - Throughput: one transaction per cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_* stay stable. Upstream stages fill, then in_ready drops to 0. No transaction is dropped or duplicated.
  - Full pipeline with out_ready=1 accepts a new input in the same cycle (pass-through, no bubble).
- Hit counter:
  - On an output handshake (out_valid & out_ready) with out_f != 0, hit_cnt increments by 1 and saturates at all-ones.
  - cnt_clr=1 sets hit_cnt to 0 next cycle. If clear and increment coincide, clear wins and the result is 0.
- Reset (rst_n=0 at a clock edge):
  - All v[k]=0 and all data registers 0, so out_d=out_e=out_f=out_g=0 and out_valid=0.
  - hit_cnt=0, busy=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions with no output handshake.
  - Inputs are ignored while rst_n=0.
- in_mode is captured with its own transaction, so mode changes between transactions never affect in-flight data.
- busy=1 whenever any stage holds a valid transaction.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1. Send a=F0, b=CC, c=AA, mode 00 -> two cycles later out_valid=1, d=AA, e=3C, f=42, g=55; hit_cnt=1.
- Same operands, modes 01/10/11 back-to-back on consecutive cycles -> f=96, E8, 69 on three consecutive cycles, each 2 cycles after input; hit_cnt +3.
- Send a=00, b=00, c=00, mode 00 -> f=00, g=FF, e=00; hit_cnt unchanged.
- Hold out_ready=0 and stream 4 transactions -> in_ready drops after 2 accepted; outputs stay stable. Release out_ready -> all delivered in order, no loss or duplication.
- Preload hit_cnt to all-ones with CNT_W=2 (3 hits), then a further hit -> stays 3. Assert cnt_clr in the same cycle as a hit -> 0.
- With 2 valid transactions in flight, pull rst_n low for 1 cycle -> out_valid=0, busy=0, hit_cnt=0, outputs 00, in_ready=1 the next cycle; no stale output ever appears.

Source files
------------

// File: rtl/b1_vec_pipe.sv
// Bit-parallel b1 logic cell with a selectable f-function, an elastic valid/ready
// register pipeline and a saturating count of delivered non-zero f results.
module b1_vec_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_e,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_g,
  output logic [CNT_W-1:0] hit_cnt,
  input  logic             cnt_clr,
  output logic             busy
);

  logic [WIDTH-1:0] f_comb;

  always_comb begin
    f_comb = '0;
    unique case (in_mode)
      2'b00:   f_comb = (~in_a & ~in_b & in_c) | (in_a & in_b & ~in_c);
      2'b01:   f_comb = in_a ^ in_b ^ in_c;
      2'b10:   f_comb = (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
      default: f_comb = ~(in_a ^ in_b ^ in_c);
    endcase
  end

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            adv;
  logic [STAGES-1:0][WIDTH-1:0] d_q;
  logic [STAGES-1:0][WIDTH-1:0] e_q;
  logic [STAGES-1:0][WIDTH-1:0] f_q;
  logic [STAGES-1:0][WIDTH-1:0] g_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;

  // A stage may move when any stage at or below it (toward the output) has room,
  // or the sink drains the last one; unrolled to avoid a bit-level feedback chain.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      room   = room | ~v_q[k];
      adv[k] = room;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && (out_f != '0) && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      d_q   <= '0;
      e_q   <= '0;
      f_q   <= '0;
      g_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (adv[0]) begin
        v_q[0] <= in_valid;
        d_q[0] <= in_c;
        e_q[0] <= in_a ^ in_b;
        f_q[0] <= f_comb;
        g_q[0] <= ~in_c;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
          e_q[k] <= e_q[k-1];
          f_q[k] <= f_q[k-1];
          g_q[k] <= g_q[k-1];
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign out_d     = d_q[STAGES-1];
  assign out_e     = e_q[STAGES-1];
  assign out_f     = f_q[STAGES-1];
  assign out_g     = g_q[STAGES-1];
  assign hit_cnt   = cnt_q;
  assign busy      = |v_q;

endmodule

// File: tb/tb_b1_vec_pipe.sv
// Scoreboard bench for b1_vec_pipe: a wide-counter instance and a 2-bit-counter
// instance share stimulus; a monitor pops expected results on each output handshake.
module tb_b1_vec_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic cnt_clr = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0, in_c = '0;
  logic [1:0] in_mode = '0;

  logic in_ready, out_valid, busy;
  logic [W-1:0] out_d, out_e, out_f, out_g;
  logic [15:0] hit_cnt;
  logic in_ready2, out_valid2, busy2;
  logic [W-1:0] out_d2, out_e2, out_f2, out_g2;
  logic [1:0] hit_cnt2;

  b1_vec_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_e(out_e), .out_f(out_f), .out_g(out_g),
    .hit_cnt(hit_cnt), .cnt_clr(cnt_clr), .busy(busy)
  );

  b1_vec_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_d(out_d2), .out_e(out_e2), .out_f(out_f2), .out_g(out_g2),
    .hit_cnt(hit_cnt2), .cnt_clr(cnt_clr), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d, e, f, g;
    bit           lat;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int exp_cnt2 = 0;
  bit started = 0;
  bit rand_bp = 0;
  bit hold_ready = 1;
  bit lat_mode = 0;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_bp ? ($urandom % 4 != 0) : hold_ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Spec-level truth table: count the ones among a, b, c per bit.
  function automatic logic [W-1:0] ref_f(input logic [W-1:0] a, b, c, input logic [1:0] m);
    logic [W-1:0] r;
    int n;
    r = '0;
    for (int i = 0; i < W; i++) begin
      n = int'(a[i]) + int'(b[i]) + int'(c[i]);
      case (m)
        2'd0:    r[i] = c[i] ? (n == 1) : (n == 2);
        2'd1:    r[i] = (n % 2) == 1;
        2'd2:    r[i] = n >= 2;
        default: r[i] = (n % 2) == 0;
      endcase
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, b, c, input logic [1:0] m);
    exp_t x;
    int w = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    in_mode = m;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      x = '{d: c, e: a ^ b, f: ref_f(a, b, c, m), g: ~c, lat: lat_mode, cyc: cyc};
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask

  // Monitor: hit-counter model, output stability under stall, in-order scoreboard.
  initial begin
    logic stall;
    logic [W-1:0] pd, pe, pf, pg;
    bit hit;
    exp_t x;
    stall = 1'b0;
    pd = '0; pe = '0; pf = '0; pg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt = 0;
        exp_cnt2 = 0;
        stall = 1'b0;
        started = 1;
        continue;
      end
      if (!started) continue;
      chk("hit_cnt", hit_cnt, exp_cnt);
      chk("hit_cnt_w2", hit_cnt2, exp_cnt2);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_d", out_d, pd);
        chk("stall_e", out_e, pe);
        chk("stall_f", out_f, pf);
        chk("stall_g", out_g, pg);
      end
      hit = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=f_%0h required=no_output", out_f);
        end else begin
          x = sb.pop_front();
          chk("out_d", out_d, x.d);
          chk("out_e", out_e, x.e);
          chk("out_f", out_f, x.f);
          chk("out_g", out_g, x.g);
          if (x.lat) chk("latency", cyc - x.cyc, S);
          hit = (x.f != '0);
        end
      end
      if (cnt_clr) begin
        exp_cnt = 0;
        exp_cnt2 = 0;
      end else if (hit) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
      stall = out_valid && !out_ready;
      pd = out_d; pe = out_e; pf = out_f; pg = out_g;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_f", out_f, 0);
    chk("rst_out_g", out_g, 0);
    chk("rst_hit_cnt", hit_cnt, 0);

    // Directed operands, no backpressure, latency checked.
    hold_ready = 1;
    lat_mode = 1;
    @(posedge clk);
    #1;
    send(8'hF0, 8'hCC, 8'hAA, 2'b00);
    send(8'hF0, 8'hCC, 8'hAA, 2'b01);
    send(8'hF0, 8'hCC, 8'hAA, 2'b10);
    send(8'hF0, 8'hCC, 8'hAA, 2'b11);
    send(8'h00, 8'h00, 8'h00, 2'b00);
    repeat (4) @(posedge clk);
    #1;
    chk("hits_directed", hit_cnt, 4);
    chk("hits_w2_saturated", hit_cnt2, 3);

    send(8'hF0, 8'hCC, 8'hAA, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    chk("hits_after_extra", hit_cnt, 5);
    chk("hits_w2_stays_max", hit_cnt2, 3);

    // Clear lands on the same edge as a hit handshake.
    send(8'hF0, 8'hCC, 8'hAA, 2'b01);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_wins", hit_cnt, 0);
    chk("clr_wins_w2", hit_cnt2, 0);
    lat_mode = 0;

    // Backpressure: two fill the pipe, then input stalls until release.
    hold_ready = 0;
    @(posedge clk);
    #1;
    send(8'hF0, 8'hCC, 8'hAA, 2'b01);
    send(8'h0F, 8'h33, 8'h55, 2'b10);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    fork
      begin
        send(8'h12, 8'h34, 8'h56, 2'b11);
        send(8'hA5, 8'h5A, 8'hFF, 2'b00);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        hold_ready = 1;
      end
    join
    wait_drain();

    // Reset with two transactions in flight.
    hold_ready = 0;
    @(posedge clk);
    #1;
    send(8'hF0, 8'hCC, 8'hAA, 2'b10);
    send(8'h0F, 8'h33, 8'h55, 2'b01);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_hit_cnt", hit_cnt, 0);
    chk("midrst_out_d", out_d, 0);
    chk("midrst_out_e", out_e, 0);
    chk("midrst_out_f", out_f, 0);
    chk("midrst_in_ready", in_ready, 1);
    hold_ready = 1;
    repeat (6) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and occasional clears.
    rand_bp = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom % 4 == 0) begin
        cnt_clr = ($urandom % 3 == 0);
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
      end
      send(W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
    end
    rand_bp = 0;
    hold_ready = 1;
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
